// File: rtl/adding_machine_controller_if.sv
// Control bus between the adding-machine controller and its datapath/memory.
// The controller side (master) drives every strobe and observes run, the IR
// contents and the memory handshake. The datapath side (slave) is the mirror.
interface adding_machine_controller_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [7:0]       ir_in;
    logic             mem_ready;
    logic             load_IR;
    logic             load_acc;
    logic             sel_alu;
    logic             sel_bus;
    logic             pass_add;
    logic             ld_pc;
    logic             clr_pc;
    logic             inc_pc;
    logic             ir_on_adr;
    logic             pc_on_adr;
    logic             rd_mem;
    logic             wr_mem;
    logic             acc_on_dbus;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, ir_in, mem_ready,
        output load_IR, load_acc, sel_alu, sel_bus, pass_add,
               ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr,
               rd_mem, wr_mem, acc_on_dbus, state_o, instr_cnt
    );

    modport slave (
        output run, ir_in, mem_ready,
        input  load_IR, load_acc, sel_alu, sel_bus, pass_add,
               ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr,
               rd_mem, wr_mem, acc_on_dbus, state_o, instr_cnt
    );
endinterface

// File: rtl/adding_machine_controller.sv
// Moore control FSM for the adding-machine datapath: fetch / increment-PC /
// execute loop over the LDA, STA, ADD and JMP opcodes held in ir_in[7:6].
// Counts retired instructions in instr_cnt (wraps modulo 2^CNT_W).
//
// Build option ADDING_MACHINE_MEM_WAIT_EN: memory-touching states (FETCH,
// LDA, ADD, STA) stall until mem_ready=1; the bus strobes stay up through the
// stall and the register loads fire only on the ready cycle. Without it,
// mem_ready is ignored and every state lasts one cycle.
module adding_machine_controller #(
    parameter int CNT_W = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    adding_machine_controller_if.master    bus
);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_IDLE  = 3'd1,
        S_FETCH = 3'd2,
        S_INCPC = 3'd3,
        S_LDA   = 3'd4,
        S_STA   = 3'd5,
        S_ADD   = 3'd6,
        S_JMP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_ok;
    logic             exec_done;

    // Address bits are consumed by the datapath, not by the controller.
    logic [5:0]       unused_adr;
    assign unused_adr = bus.ir_in[5:0];

`ifdef ADDING_MACHINE_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ok = 1'b1;
`endif

    // State and retired-instruction counter; reset forces S_RST at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing; leaving an execute state retires the instruction
    // and samples run to decide between the next fetch and parking in idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exec_done = 1'b0;
        case (state_q)
            S_RST:   state_d = S_IDLE;
            S_IDLE:  if (bus.run) state_d = S_FETCH;
            S_FETCH: if (mem_ok) state_d = S_INCPC;
            S_INCPC: begin
                case (bus.ir_in[7:6])
                    2'b00:   state_d = S_LDA;
                    2'b01:   state_d = S_STA;
                    2'b10:   state_d = S_ADD;
                    default: state_d = S_JMP;
                endcase
            end
            S_LDA, S_STA, S_ADD: exec_done = mem_ok;
            S_JMP:   exec_done = 1'b1;
            default: state_d = S_RST;
        endcase
        if (exec_done) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = bus.run ? S_FETCH : S_IDLE;
        end
    end

    // Strobe decode from the current state; register loads wait for mem_ok.
    always_comb begin
        bus.load_IR     = 1'b0;
        bus.load_acc    = 1'b0;
        bus.sel_alu     = 1'b0;
        bus.sel_bus     = 1'b0;
        bus.pass_add    = 1'b0;
        bus.ld_pc       = 1'b0;
        bus.clr_pc      = 1'b0;
        bus.inc_pc      = 1'b0;
        bus.ir_on_adr   = 1'b0;
        bus.pc_on_adr   = 1'b0;
        bus.rd_mem      = 1'b0;
        bus.wr_mem      = 1'b0;
        bus.acc_on_dbus = 1'b0;
        case (state_q)
            S_RST:   bus.clr_pc = 1'b1;
            S_FETCH: begin
                bus.pc_on_adr = 1'b1;
                bus.rd_mem    = 1'b1;
                bus.load_IR   = mem_ok;
            end
            S_INCPC: bus.inc_pc = 1'b1;
            S_LDA: begin
                bus.ir_on_adr = 1'b1;
                bus.rd_mem    = 1'b1;
                bus.sel_bus   = 1'b1;
                bus.load_acc  = mem_ok;
            end
            S_ADD: begin
                bus.ir_on_adr = 1'b1;
                bus.rd_mem    = 1'b1;
                bus.sel_alu   = 1'b1;
                bus.pass_add  = 1'b1;
                bus.load_acc  = mem_ok;
            end
            S_STA: begin
                bus.ir_on_adr   = 1'b1;
                bus.wr_mem      = 1'b1;
                bus.acc_on_dbus = 1'b1;
            end
            S_JMP:   bus.ld_pc = 1'b1;
            default: ;
        endcase
    end

    assign bus.state_o   = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule
